processor_mc: RTL

Multi-cycle successor to the single-cycle core: fetches, executes and accesses data memory over separate instruction and data ports, each with a req/ready handshake, so memories may insert any number of wait states. It reuses the existing `control_unit`, `reg_file` and `alu` unchanged. It replaces `program_counter` with an internal stallable PC. The address width and reset vector are parametrised. It sits at the top of the CPU, between the memory system and the datapath.

---
 rtl/processor_mc_pkg.sv | 45 ++++
 rtl/alu.sv | 26 ++
 rtl/control_unit.sv | 81 ++++++++
 rtl/processor_mc_fsm.sv | 83 ++++++++
 rtl/reg_file.sv | 36 +++
 rtl/processor_mc.sv | 143 ++++++++++++++
 6 files changed

// File: rtl/processor_mc_pkg.sv
// processor_mc_pkg: shared types and constants for the multi-cycle core.
//   state_e   : controller states (FETCH, EXEC, MEM)
//   opcode_e  : instruction opcodes, instr[31:28]
//   alu_op_e  : ALU operation select
//   PC_STEP   : byte increment between sequential instructions
// Instruction format: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2,
// [15:0] imm16.
package processor_mc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2
  } state_e;

  localparam int PC_STEP = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_ADDI  = 4'd5,   // rd = rs1 + sign-extended imm16
    OP_ORI   = 4'd6,   // rd = rs1 | zero-extended imm16
    OP_LUI   = 4'd7,   // rd = imm16 << 16
    OP_LW_IM = 4'd8,   // rd = mem[imm16]
    OP_LW_R  = 4'd9,   // rd = mem[rs1]
    OP_SW_IM = 4'd10,  // mem[imm16] = rs2
    OP_SW_R  = 4'd11,  // mem[rs1] = rs2
    OP_JMP   = 4'd12,  // pc = imm16
    OP_JR    = 4'd13,  // pc = rs1
    OP_NOP   = 4'd14
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit arithmetic/logic unit.
// Ports:
//   alu_op in 3 (alu_op_e), a in 32, b in 32, result out 32
module alu
  import processor_mc_pkg::*;
(
  input  logic [2:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: decodes an instruction word into datapath controls.
// Ports:
//   instr            in  32  instruction register
//   rd, rs1, rs2     out 4   register addresses
//   imm              out 32  formatted immediate (sign/zero extended or shifted)
//   alu_op           out 3   alu_op_e encoding
//   alu_src_imm      out 1   ALU operand B is the immediate
//   reg_write_enable out 1   instruction writes rd (loads included)
//   mem_read/mem_write       load / store
//   mem_read_im/mem_write_im address comes from the immediate
//   jump_en          out 1   PC takes the jump target
//   jump_reg         out 1   jump target is rs1 data rather than imm
module control_unit
  import processor_mc_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [31:0] imm,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write_enable,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_read_im,
  output logic        mem_write_im,
  output logic        jump_en,
  output logic        jump_reg
);

  assign rd  = instr[27:24];
  assign rs1 = instr[23:20];
  assign rs2 = instr[19:16];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    imm              = {16'h0, instr[15:0]};
    alu_op           = ALU_ADD;
    alu_src_imm      = 1'b0;
    reg_write_enable = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_read_im      = 1'b0;
    mem_write_im     = 1'b0;
    jump_en          = 1'b0;
    jump_reg         = 1'b0;
    case (opcode_e'(instr[31:28]))
      OP_ADD:  reg_write_enable = 1'b1;
      OP_SUB:  begin alu_op = ALU_SUB; reg_write_enable = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; reg_write_enable = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  reg_write_enable = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; reg_write_enable = 1'b1; end
      OP_ADDI: begin
        imm              = {{16{instr[15]}}, instr[15:0]};
        alu_src_imm      = 1'b1;
        reg_write_enable = 1'b1;
      end
      OP_ORI:  begin
        alu_op           = ALU_OR;
        alu_src_imm      = 1'b1;
        reg_write_enable = 1'b1;
      end
      OP_LUI:  begin
        imm              = {instr[15:0], 16'h0};
        alu_op           = ALU_PASS_B;
        alu_src_imm      = 1'b1;
        reg_write_enable = 1'b1;
      end
      OP_LW_IM: begin mem_read = 1'b1; mem_read_im = 1'b1; reg_write_enable = 1'b1; end
      OP_LW_R:  begin mem_read = 1'b1; reg_write_enable = 1'b1; end
      OP_SW_IM: begin mem_write = 1'b1; mem_write_im = 1'b1; end
      OP_SW_R:  mem_write = 1'b1;
      OP_JMP:   jump_en = 1'b1;
      OP_JR:    begin jump_en = 1'b1; jump_reg = 1'b1; end
      default:  ;  // OP_NOP and unused opcodes do nothing
    endcase
  end

endmodule

// File: rtl/processor_mc_fsm.sv
// processor_mc_fsm: FETCH/EXEC/MEM sequencer for processor_mc.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_read, mem_write   decoded load/store of the current IR
//   reg_write_enable      decoded register write of the current IR
//   imem_ready, dmem_ready memory handshakes
//   imem_req, dmem_req, dmem_we   memory requests (0 during reset)
//   ir_load               latch imem_rdata into IR this cycle
//   pc_update             retire: advance PC this cycle
//   reg_write             write the register file this cycle
//   in_mem                current state is MEM (selects load data)
module processor_mc_fsm
  import processor_mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic reg_write_enable,
  input  logic imem_ready,
  input  logic dmem_ready,
  output logic imem_req,
  output logic dmem_req,
  output logic dmem_we,
  output logic ir_load,
  output logic pc_update,
  output logic reg_write,
  output logic in_mem
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Requests depend only on state and reset, never on *_ready. Gating with
  // reset drops a pending request in the cycle reset rises and suppresses
  // any retire strobe a late ready would otherwise cause.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    pc_update = 1'b0;
    reg_write = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (mem_read || mem_write) begin
            state_d = MEM;
          end else begin
            pc_update = 1'b1;
            reg_write = reg_write_enable;
            state_d   = FETCH;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ready) begin
            pc_update = 1'b1;
            reg_write = mem_read;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign in_mem = (state_q == MEM);

endmodule

// File: rtl/reg_file.sv
// reg_file: 16 x 32-bit registers, two combinational read ports, one
// synchronous write port. Cleared by reset.
// Ports:
//   clk, reset (sync, active-high), we, waddr 4, wdata 32,
//   raddr1 4, raddr2 4, rdata1 32, rdata2 32
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is cleared on reset because software relies on
      // registers starting at zero; that forces a flop implementation
      // rather than a RAM macro, acceptable at 16 entries.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/processor_mc.sv
// processor_mc: multi-cycle CPU top. Fetches over the instruction port,
// executes, and performs loads/stores over the data port; both ports use a
// req/ready handshake so memories may insert wait states.
// Parameters: ADDR_W (3..32) address width, RESET_PC (multiple of 4).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req/imem_addr out          fetch request and address (PC)
//   imem_ready/imem_rdata in        fetch completion and instruction
//   dmem_req/dmem_we/dmem_addr/dmem_wdata out   data request
//   dmem_ready/dmem_rdata in        data completion and load data
// Optional (macro PROCESSOR_MC_PERF_EN):
//   cycle_count out 32              non-reset cycles
//   instret_count out 32            retired instructions
module processor_mc
  import processor_mc_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata
`ifdef PROCESSOR_MC_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instret_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;

  logic [3:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [2:0]  alu_op;
  logic        alu_src_imm, reg_write_enable;
  logic        mem_read, mem_write, mem_read_im, mem_write_im;
  logic        jump_en, jump_reg;

  logic        ir_load, pc_update, reg_write, in_mem;
  logic [31:0] rdata1, rdata2, alu_b, alu_result, rf_wdata;
  logic [31:0] jump_addr, mem_addr_full;

  processor_mc_fsm u_fsm (
    .clk              (clk),
    .reset            (reset),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .reg_write_enable (reg_write_enable),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .imem_req         (imem_req),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .ir_load          (ir_load),
    .pc_update        (pc_update),
    .reg_write        (reg_write),
    .in_mem           (in_mem)
  );

  control_unit u_control_unit (
    .instr            (ir),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .alu_op           (alu_op),
    .alu_src_imm      (alu_src_imm),
    .reg_write_enable (reg_write_enable),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_read_im      (mem_read_im),
    .mem_write_im     (mem_write_im),
    .jump_en          (jump_en),
    .jump_reg         (jump_reg)
  );

  // Loads write back in MEM; everything else writes the ALU result in EXEC.
  assign rf_wdata = in_mem ? dmem_rdata : alu_result;

  reg_file u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (reg_write),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign alu_b = alu_src_imm ? imm : rdata2;

  alu u_alu (
    .alu_op (alu_op),
    .a      (rdata1),
    .b      (alu_b),
    .result (alu_result)
  );

  assign jump_addr     = jump_reg ? rdata1 : imm;
  assign mem_addr_full = (mem_read_im || mem_write_im) ? imm : rdata1;

  // PC + PC_STEP wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (ir_load)   ir <= imem_rdata;
      if (pc_update) pc <= jump_en ? jump_addr[ADDR_W-1:0] : pc + ADDR_W'(PC_STEP);
    end
  end

  // Address/data buses read as zero whenever their request is low, which
  // also makes them zero throughout reset.
  assign imem_addr  = imem_req ? pc : '0;
  assign dmem_addr  = dmem_req ? mem_addr_full[ADDR_W-1:0] : '0;
  assign dmem_wdata = (dmem_req && dmem_we) ? rdata2 : '0;

`ifdef PROCESSOR_MC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (pc_update) instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule
